// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: default geometry,
// next-PC source encoding and the alignment helper.
package pc_pkg;

   localparam int PC_ADDR_W       = 32;
   localparam int PC_INSTR_BYTES  = 4;
   localparam int PC_RESET_VECTOR = 0;
   localparam int PC_RAS_DEPTH    = 4;

   // Source of the next PC value, one per priority level.
   typedef enum logic [2:0] {
      PC_SEL_SEQ,
      PC_SEL_HOLD,
      PC_SEL_BR,
      PC_SEL_JMP,
      PC_SEL_RET
   } pc_sel_t;

   // Number of low address bits that must be zero for an aligned instruction.
   function automatic int align_lsb(input int instr_bytes);
      return (instr_bytes <= 1) ? 0 : $clog2(instr_bytes);
   endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push when full overwrites the oldest
// entry; a pop on an empty stack is ignored. Push and pop in the same
// cycle replace the current top (net depth unchanged).
module pc_ras #(
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  logic              pop,
   input  logic [ADDR_W-1:0] push_data,
   output logic [ADDR_W-1:0] top,
   output logic              empty,
   output logic              full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [ADDR_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  ptr;        // next free slot
   logic [PTR_W-1:0]  top_idx;    // most recently pushed slot
   logic [PTR_W-1:0]  ptr_inc;
   logic [PTR_W-1:0]  wr_idx;
   logic [CNT_W-1:0]  count;
   logic              pop_ok;

   assign pop_ok  = pop & ~empty;
   assign top_idx = (ptr == '0) ? PTR_W'(DEPTH - 1) : ptr - PTR_W'(1);
   assign ptr_inc = (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
   assign wr_idx  = pop_ok ? top_idx : ptr;

   assign top   = mem[top_idx];
   assign empty = (count == '0);
   assign full  = (count == CNT_W'(DEPTH));

   // Pointer and occupancy tracking; count saturates at DEPTH on overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr   <= '0;
         count <= '0;
      end else if (push && !pop_ok) begin
         ptr <= ptr_inc;
         if (!full) count <= count + CNT_W'(1);
      end else if (pop_ok && !push) begin
         ptr   <= top_idx;
         count <= count - CNT_W'(1);
      end
   end

   // Entry storage.
   // NOTE: storage is not reset; the occupancy count alone decides which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_idx] <= push_data;
   end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: PC register plus next-PC selection (sequential,
// branch, jump, hold, optional return). Redirect targets are force-aligned
// and flag a one-cycle misaligned pulse.
// Optional return-address stack enabled by defining PC_RAS_EN.
module pc_unit
   import pc_pkg::*;
#(
   parameter int                ADDR_W       = PC_ADDR_W,
   parameter int                INSTR_BYTES  = PC_INSTR_BYTES,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(PC_RESET_VECTOR),
   parameter int                RAS_DEPTH    = PC_RAS_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_offset,
   input  logic              jump,
   input  logic [ADDR_W-1:0] jump_target,
   input  logic              call,
   input  logic              ret,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_next,
   output logic [ADDR_W-1:0] pc_plus,
   output logic              misaligned,
   output logic              ras_empty,
   output logic              ras_full
);

   localparam int                ALIGN_LSB  = align_lsb(INSTR_BYTES);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((64'd1 << ALIGN_LSB) - 64'd1);

   logic [ADDR_W-1:0] pc_q;
   logic              mis_q;
   logic [ADDR_W-1:0] raw_target;
   logic              redirect;
   logic              mis_next;
   logic              ret_ok;
   logic [ADDR_W-1:0] ras_top;
   pc_sel_t           sel;

   assign pc         = pc_q;
   assign misaligned = mis_q;
   assign pc_plus    = pc_q + ADDR_W'(INSTR_BYTES);

`ifdef PC_RAS_EN
   logic ras_push;

   // A return is honoured only when the stack holds an address.
   assign ret_ok   = ret & ~ras_empty;
   assign ras_push = call & jump;

   pc_ras #(
      .ADDR_W (ADDR_W),
      .DEPTH  (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (ras_push),
      .pop       (ret_ok),
      .push_data (pc_plus),
      .top       (ras_top),
      .empty     (ras_empty),
      .full      (ras_full)
   );
`else
   // Without the stack, call/ret have no effect.
   wire ras_unused = ^{call, ret, (RAS_DEPTH < 2)};

   assign ret_ok    = 1'b0;
   assign ras_top   = '0;
   assign ras_empty = 1'b1;
   assign ras_full  = 1'b0;
`endif

   // Priority select of the next-PC source.
   always_comb begin
      // NOTE: default first so every path assigns sel and no latch is inferred.
      sel = PC_SEL_SEQ;
      if (ret_ok)            sel = PC_SEL_RET;
      else if (jump)         sel = PC_SEL_JMP;
      else if (branch_taken) sel = PC_SEL_BR;
      else if (stall)        sel = PC_SEL_HOLD;
   end

   // Next-PC datapath, alignment and misalignment detection.
   always_comb begin
      raw_target = pc_plus;
      redirect   = 1'b0;
      case (sel)
         PC_SEL_RET: begin raw_target = ras_top;             redirect = 1'b1; end
         PC_SEL_JMP: begin raw_target = jump_target;         redirect = 1'b1; end
         PC_SEL_BR:  begin raw_target = pc_q + branch_offset; redirect = 1'b1; end
         PC_SEL_HOLD: raw_target = pc_q;
         default:     raw_target = pc_plus;
      endcase
      pc_next  = raw_target & ~ALIGN_MASK;
      mis_next = redirect & (|(raw_target & ALIGN_MASK));
   end

   // PC register and one-cycle misaligned flag.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      if (!rst_n) begin
         pc_q  <= RESET_VECTOR;
         mis_q <= 1'b0;
      end else begin
         pc_q  <= pc_next;
         mis_q <= mis_next;
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios followed by random
// stimulus, compared against a queue-based behavioural model.
// Stack behaviour is modelled when PC_RAS_EN is defined.
module tb_pc_unit;
   import pc_pkg::*;

   localparam int AW    = 32;
   localparam int IB    = 4;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          stall = 1'b0;
   logic          branch_taken = 1'b0;
   logic [AW-1:0] branch_offset = '0;
   logic          jump = 1'b0;
   logic [AW-1:0] jump_target = '0;
   logic          call = 1'b0;
   logic          ret = 1'b0;
   logic [AW-1:0] pc;
   logic [AW-1:0] pc_next;
   logic [AW-1:0] pc_plus;
   logic          misaligned;
   logic          ras_empty;
   logic          ras_full;

   int checks = 0;
   int failures = 0;

   // Reference state
   logic [AW-1:0] exp_pc = '0;
   logic          exp_mis = 1'b0;
   logic [AW-1:0] ras_q[$];

   always #5 clk = ~clk;

   pc_unit #(
      .ADDR_W       (AW),
      .INSTR_BYTES  (IB),
      .RESET_VECTOR (32'h0),
      .RAS_DEPTH    (DEPTH)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_offset (branch_offset),
      .jump          (jump),
      .jump_target   (jump_target),
      .call          (call),
      .ret           (ret),
      .pc            (pc),
      .pc_next       (pc_next),
      .pc_plus       (pc_plus),
      .misaligned    (misaligned),
      .ras_empty     (ras_empty),
      .ras_full      (ras_full)
   );

   task automatic check(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_flags(input string tag);
`ifdef PC_RAS_EN
      check({tag, "_ras_empty"}, ras_empty, (ras_q.size() == 0));
      check({tag, "_ras_full"},  ras_full,  (ras_q.size() == DEPTH));
`else
      check({tag, "_ras_empty"}, ras_empty, 1'b1);
      check({tag, "_ras_full"},  ras_full,  1'b0);
`endif
   endtask

   // One clock cycle: drive inputs, check combinational outputs, take the
   // edge, then check registered outputs against the model.
   task automatic step(input logic st, input logic br, input logic [AW-1:0] off,
                       input logic jp, input logic [AW-1:0] tgt,
                       input logic cl, input logic rt);
      logic [AW-1:0] raw;
      logic [AW-1:0] nxt;
      logic          redir;
      logic          pop;
      stall = st; branch_taken = br; branch_offset = off;
      jump = jp; jump_target = tgt; call = cl; ret = rt;
      pop   = 1'b0;
      redir = 1'b1;
      raw   = '0;
`ifdef PC_RAS_EN
      if (rt && ras_q.size() > 0) begin
         raw = ras_q[$];
         pop = 1'b1;
      end else
`endif
      if (jp)      raw = tgt;
      else if (br) raw = exp_pc + off;
      else begin
         redir = 1'b0;
         raw   = st ? exp_pc : exp_pc + AW'(IB);
      end
      nxt = raw & ~AW'(IB - 1);
      #1;
      check("pc_next", pc_next, nxt);
      check("pc_plus", pc_plus, exp_pc + AW'(IB));
      @(posedge clk);
      #1;
`ifdef PC_RAS_EN
      if (pop) void'(ras_q.pop_back());
      if (cl && jp) begin
         ras_q.push_back(exp_pc + AW'(IB));
         if (ras_q.size() > DEPTH) void'(ras_q.pop_front());
      end
`endif
      exp_mis = redir && ((raw & AW'(IB - 1)) != '0);
      exp_pc  = nxt;
      check("pc", pc, exp_pc);
      check("misaligned", misaligned, exp_mis);
      check_flags("step");
   endtask

   task automatic idle();
      step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic jump_to(input logic [AW-1:0] tgt);
      step(1'b0, 1'b0, '0, 1'b1, tgt, 1'b0, 1'b0);
   endtask

   initial begin
      // Reset state
      #1;
      check("reset_pc", pc, 32'h0);
      check("reset_mis", misaligned, 1'b0);
      check("reset_empty", ras_empty, 1'b1);
      check("reset_full", ras_full, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Asynchronous reset mid-run from pc=0x40
      jump_to(32'h40);
      check("pc_at_40", pc, 32'h40);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_pc", pc, 32'h0);
      check("async_reset_mis", misaligned, 1'b0);
      exp_pc  = '0;
      exp_mis = 1'b0;
      ras_q.delete();
      check_flags("async_reset");
      @(negedge clk);
      rst_n = 1'b1;
      idle(); check("seq_4", pc, 32'h4);
      idle(); check("seq_8", pc, 32'h8);
      idle(); check("seq_c", pc, 32'hC);

      // Backward branch, then branch overriding stall
      jump_to(32'h100);
      step(1'b0, 1'b1, 32'hFFFF_FFF0, 1'b0, '0, 1'b0, 1'b0);
      check("branch_back", pc, 32'hF0);
      jump_to(32'h100);
      step(1'b1, 1'b1, 32'hFFFF_FFF0, 1'b0, '0, 1'b0, 1'b0);
      check("branch_stall", pc, 32'hF0);

      // Jump beats branch; misaligned target pulses the flag for one cycle
      step(1'b0, 1'b1, 32'h40, 1'b1, 32'h203, 1'b0, 1'b0);
      check("jump_align_pc", pc, 32'h200);
      check("jump_align_mis", misaligned, 1'b1);
      idle();
      check("mis_cleared", misaligned, 1'b0);

      // Wrap-around and hold
      jump_to(32'hFFFF_FFFC);
      idle(); check("wrap", pc, 32'h0);
      step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
      step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
      check("hold", pc, 32'h0);

      // Call/return (ignored when the stack is absent)
      jump_to(32'h10);
      step(1'b0, 1'b0, '0, 1'b1, 32'h80, 1'b1, 1'b0);
      check("call_target", pc, 32'h80);
      step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
`ifdef PC_RAS_EN
      check("second_ret_seq", pc, 32'h18);
`else
      check("ret_ignored", pc, 32'h88);
`endif

      // Stack overflow: five calls, five returns
      for (int k = 0; k < 5; k++) begin
         jump_to(AW'(k * 32'h100));
         step(1'b0, 1'b0, '0, 1'b1, 32'h1000, 1'b1, 1'b0);
      end
      for (int k = 0; k < 5; k++) begin
         step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      end
`ifdef PC_RAS_EN
      check("overflow_oldest_lost", pc, 32'h108);
`endif

      // Call and return together, during stall
      jump_to(32'h500);
      step(1'b0, 1'b0, '0, 1'b1, 32'h600, 1'b1, 1'b0);
      step(1'b1, 1'b0, '0, 1'b1, 32'h700, 1'b1, 1'b1);
      step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);

      // Random stimulus
      for (int i = 0; i < 600; i++) begin
         logic [AW-1:0] tgt;
         logic [AW-1:0] off;
         tgt = $urandom;
         off = $urandom;
         if ($urandom_range(0, 1) == 0) tgt = tgt & ~AW'(IB - 1);
         if ($urandom_range(0, 1) == 0) off = AW'($signed(off[9:0]));
         step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0, off,
              $urandom_range(0, 4) == 0, tgt,
              $urandom_range(0, 1) == 0, $urandom_range(0, 4) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
